// File: rtl/neural_branch_tracker.sv
// Branch tracker between the perceptron predictor and execute:
// in-flight queue, speculative GHR, flush and training generation.
module neural_branch_tracker #(
  parameter int DEPTH    = 4,
  parameter int HIST_LEN = 16,
  parameter int SUM_W    = 10,
  parameter int THETA    = 24
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                pred_valid,
  output logic                pred_ready,
  input  logic [31:0]         pred_pc,
  input  logic                pred_taken,
  input  logic [SUM_W-1:0]    pred_sum,
  output logic [HIST_LEN-1:0] ghr,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic                res_taken,
  input  logic [31:0]         res_target,
  output logic                flush_valid,
  output logic [31:0]         flush_pc,
  output logic                train_valid,
  input  logic                train_ready,
  output logic [31:0]         train_pc,
  output logic                train_taken,
  output logic [HIST_LEN-1:0] train_hist,
  output logic                err_underflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]         pc;
    logic                taken;
    logic [SUM_W-1:0]    sum;
    logic [HIST_LEN-1:0] hist;
  } ent_t;

  ent_t             q [DEPTH];
  ent_t             hd;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic             push;
  logic             res_fire;
  logic             pop;
  logic             mis;
  logic             low;
  logic             need_train;
  logic [SUM_W-1:0] mag;

  assign hd         = q[head];
  assign pred_ready = count < (PW+1)'(DEPTH);
  assign res_ready  = !train_valid | train_ready;
  assign push       = pred_valid & pred_ready;
  assign res_fire   = res_valid & res_ready;
  assign pop        = res_fire & (count != '0);
  assign mis        = pop & (hd.taken != res_taken);

  // Unsigned view of the negation makes the most negative sum 2^(SUM_W-1)
  assign mag = hd.sum[SUM_W-1] ? (~hd.sum + SUM_W'(1)) : hd.sum;
  assign low = mag <= SUM_W'(THETA);
  assign need_train = pop & (mis | low);

  always_ff @(posedge CLK) begin
    if (push)
      q[tail] <= '{pred_pc, pred_taken, pred_sum, ghr};
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ghr           <= '0;
      flush_valid   <= 1'b0;
      flush_pc      <= '0;
      train_valid   <= 1'b0;
      train_pc      <= '0;
      train_taken   <= 1'b0;
      train_hist    <= '0;
      err_underflow <= 1'b0;
    end else begin
      flush_valid <= mis;
      if (mis)
        flush_pc <= res_taken ? res_target : hd.pc + 32'd4;

      if (need_train) begin
        train_valid <= 1'b1;
        train_pc    <= hd.pc;
        train_taken <= res_taken;
        train_hist  <= hd.hist;
      end else if (train_ready) begin
        train_valid <= 1'b0;
      end

      if (res_fire && count == '0)
        err_underflow <= 1'b1;

      // A flush discards everything, including a same-cycle push
      if (mis) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        ghr   <= {hd.hist[HIST_LEN-2:0], res_taken};
      end else begin
        if (push) begin
          tail <= tail + PW'(1);
          ghr  <= {ghr[HIST_LEN-2:0], pred_taken};
        end
        if (pop)
          head <= head + PW'(1);
        if (push && !pop)
          count <= count + (PW+1)'(1);
        else if (!push && pop)
          count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_neural_branch_tracker.sv
// Self-checking bench for neural_branch_tracker using a
// reference queue model and an expected-output scoreboard.
module tb_neural_branch_tracker;

  logic        CLK;
  logic        RES;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [9:0]  pred_sum;
  logic [15:0] ghr;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        train_valid;
  logic        train_ready;
  logic [31:0] train_pc;
  logic        train_taken;
  logic [15:0] train_hist;
  logic        err_underflow;

  neural_branch_tracker dut (
    .CLK(CLK), .RES(RES),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_sum(pred_sum), .ghr(ghr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_target(res_target),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .train_valid(train_valid), .train_ready(train_ready),
    .train_pc(train_pc), .train_taken(train_taken),
    .train_hist(train_hist), .err_underflow(err_underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [9:0]  sum;
    logic [15:0] hist;
  } ent_t;

  typedef struct packed {
    logic        flush;
    logic [31:0] fpc;
    logic        train;
    logic [31:0] tpc;
    logic        ttk;
    logic [15:0] thist;
  } exp_t;

  ent_t        mq [$];
  exp_t        sb [$];
  logic [15:0] mghr;
  logic        m_err;
  int          tests;
  int          fails;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_resolve(input logic tk, input logic [31:0] tgt,
                               output exp_t e);
    ent_t h;
    int   s;
    e = '0;
    if (mq.size() == 0) begin
      m_err = 1'b1;
      return;
    end
    h = mq.pop_front();
    s = $signed(h.sum);
    if (s < 0) s = -s;
    e.train = (h.tk != tk) || (s <= 24);
    e.tpc   = h.pc;
    e.ttk   = tk;
    e.thist = h.hist;
    if (h.tk != tk) begin
      e.flush = 1'b1;
      e.fpc   = tk ? tgt : h.pc + 32'd4;
      mq.delete();
      mghr = {h.hist[14:0], tk};
    end
  endtask

  task automatic do_reset;
    pred_valid  = 1'b0;
    res_valid   = 1'b0;
    train_ready = 1'b1;
    RES = 1'b0;
    tick();
    RES = 1'b1;
    mq.delete();
    sb.delete();
    mghr  = '0;
    m_err = 1'b0;
  endtask

  task automatic do_cycle(input bit pv, input logic [31:0] pc,
                          input bit tk, input logic [9:0] sum,
                          input bit rv, input bit rtk,
                          input logic [31:0] rtgt);
    exp_t e;
    bit   rdy;
    e = '0;
    pred_valid  = pv;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_sum    = sum;
    res_valid   = rv;
    res_taken   = rtk;
    res_target  = rtgt;
    train_ready = 1'b1;
    #1;
    rdy = mq.size() < 4;
    tests++;
    if (pred_ready !== rdy) begin
      fails++;
      $display("FAIL pred_ready pc=%h: got %b want %b", pc, pred_ready, rdy);
    end
    tests++;
    if (res_ready !== 1'b1) begin
      fails++;
      $display("FAIL res_ready: got %b want 1", res_ready);
    end
    if (rv) model_resolve(rtk, rtgt, e);
    if (pv && rdy && !e.flush) begin
      mq.push_back('{pc, tk, sum, mghr});
      mghr = {mghr[14:0], tk};
    end
    sb.push_back(e);
    tick();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    e = sb.pop_front();
    tests++;
    if (flush_valid !== e.flush) begin
      fails++;
      $display("FAIL flush_valid: got %b want %b", flush_valid, e.flush);
    end
    if (e.flush) begin
      tests++;
      if (flush_pc !== e.fpc) begin
        fails++;
        $display("FAIL flush_pc: got %h want %h", flush_pc, e.fpc);
      end
    end
    tests++;
    if (train_valid !== e.train) begin
      fails++;
      $display("FAIL train_valid: got %b want %b", train_valid, e.train);
    end
    if (e.train) begin
      tests++;
      if ({train_pc, train_taken, train_hist} !== {e.tpc, e.ttk, e.thist}) begin
        fails++;
        $display("FAIL train_payload: got %h/%b/%h want %h/%b/%h",
                 train_pc, train_taken, train_hist, e.tpc, e.ttk, e.thist);
      end
    end
    tests++;
    if (ghr !== mghr) begin
      fails++;
      $display("FAIL ghr: got %h want %h", ghr, mghr);
    end
    tests++;
    if (err_underflow !== m_err) begin
      fails++;
      $display("FAIL err_underflow: got %b want %b", err_underflow, m_err);
    end
  endtask

  task automatic push_br(input logic [31:0] pc, input bit tk,
                         input logic [9:0] sum);
    do_cycle(1'b1, pc, tk, sum, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve_br(input bit tk, input logic [31:0] tgt);
    do_cycle(1'b0, 32'h0, 1'b0, 10'd0, 1'b1, tk, tgt);
  endtask

  task automatic test_reset;
    RES = 1'b0;
    pred_valid = 1'b1;
    pred_taken = 1'b1;
    pred_pc    = 32'h40;
    pred_sum   = 10'd3;
    res_valid  = 1'b0;
    train_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({flush_valid, flush_pc, train_valid, train_pc, train_taken,
         train_hist, err_underflow, ghr} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got fv=%b fpc=%h tv=%b tpc=%h tt=%b th=%h err=%b ghr=%h want all 0",
               flush_valid, flush_pc, train_valid, train_pc, train_taken,
               train_hist, err_underflow, ghr);
    end
    tests++;
    if ({pred_ready, res_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready: got %b%b want 11", pred_ready, res_ready);
    end
    pred_valid = 1'b0;
    RES = 1'b1;
    mq.delete();
    mghr  = '0;
    m_err = 1'b0;
    push_br(32'h80, 1'b1, 10'd100);
    tests++;
    if (ghr !== 16'h0001) begin
      fails++;
      $display("FAIL first_push_ghr: got %h want 0001", ghr);
    end
    resolve_br(1'b1, 32'h0);
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 4; i++)
      push_br(32'h100 + 32'(4 * i), i[0], 10'd100);
    tests++;
    if (pred_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b want 0", pred_ready);
    end
    push_br(32'h110, 1'b1, 10'd100);
    for (int i = 0; i < 4; i++)
      resolve_br(i[0], 32'h0);
  endtask

  task automatic test_mispredict;
    logic [7:0] pat;
    pat = 8'hF0;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      push_br(32'h1000, pat[i], 10'd100);
      resolve_br(pat[i], 32'h0);
    end
    tests++;
    if (ghr !== 16'h00F0) begin
      fails++;
      $display("FAIL setup_ghr: got %h want 00F0", ghr);
    end
    push_br(32'h200, 1'b0, 10'd100);
    push_br(32'h204, 1'b1, 10'd100);
    resolve_br(1'b1, 32'h400);
    tests++;
    if ({flush_valid, flush_pc, ghr} !== {1'b1, 32'h400, 16'h01E1}) begin
      fails++;
      $display("FAIL mis_flush: got %b/%h/%h want 1/00000400/01E1",
               flush_valid, flush_pc, ghr);
    end
    tests++;
    if ({train_valid, train_pc, train_taken, train_hist} !==
        {1'b1, 32'h200, 1'b1, 16'h00F0}) begin
      fails++;
      $display("FAIL mis_train: got %b/%h/%b/%h want 1/00000200/1/00F0",
               train_valid, train_pc, train_taken, train_hist);
    end
    tick();
    tests++;
    if (flush_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_pulse: got %b want 0", flush_valid);
    end
    for (int i = 0; i < 5; i++)
      push_br(32'h300 + 32'(4 * i), 1'b1, 10'd100);
  endtask

  task automatic test_low_conf;
    do_reset();
    push_br(32'h300, 1'b1, -10'sd24);
    resolve_br(1'b1, 32'h0);
    tests++;
    if ({train_valid, flush_valid, train_pc} !== {1'b1, 1'b0, 32'h300}) begin
      fails++;
      $display("FAIL low_conf_train: got tv=%b fv=%b pc=%h want 1/0/300",
               train_valid, flush_valid, train_pc);
    end
    push_br(32'h304, 1'b0, 10'h200);
    resolve_br(1'b0, 32'h0);
    tests++;
    if (train_valid !== 1'b0) begin
      fails++;
      $display("FAIL min_sum_train: got %b want 0", train_valid);
    end
    push_br(32'h308, 1'b1, 10'd25);
    resolve_br(1'b1, 32'h0);
    push_br(32'h30C, 1'b0, 10'd24);
    resolve_br(1'b0, 32'h0);
  endtask

  task automatic test_backpressure;
    exp_t e;
    do_reset();
    push_br(32'h500, 1'b0, 10'd5);
    push_br(32'h504, 1'b1, 10'd200);
    train_ready = 1'b0;
    res_valid   = 1'b1;
    res_taken   = 1'b0;
    res_target  = 32'h0;
    #1;
    tests++;
    if (res_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready0: got %b want 1", res_ready);
    end
    model_resolve(1'b0, 32'h0, e);
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    tests++;
    if ({train_valid, train_pc, flush_valid} !== {e.train, e.tpc, 1'b0}) begin
      fails++;
      $display("FAIL bp_load: got %b/%h/%b want %b/%h/0",
               train_valid, train_pc, flush_valid, e.train, e.tpc);
    end
    res_target = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (res_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall_ready: got %b want 0", res_ready);
      end
      tick();
      tests++;
      if ({train_valid, train_pc, train_hist, flush_valid} !==
          {1'b1, e.tpc, e.thist, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold: got %b/%h/%h/%b want 1/%h/%h/0",
                 train_valid, train_pc, train_hist, flush_valid,
                 e.tpc, e.thist);
      end
    end
    train_ready = 1'b1;
    #1;
    tests++;
    if (res_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b want 1", res_ready);
    end
    model_resolve(1'b0, 32'h600, e);
    sb.push_back(e);
    tick();
    res_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if ({flush_valid, flush_pc, train_valid, train_pc, train_taken, ghr} !==
        {e.flush, e.fpc, e.train, e.tpc, e.ttk, mghr}) begin
      fails++;
      $display("FAIL bp_resume: got %b/%h/%b/%h/%b/%h want %b/%h/%b/%h/%b/%h",
               flush_valid, flush_pc, train_valid, train_pc, train_taken, ghr,
               e.flush, e.fpc, e.train, e.tpc, e.ttk, mghr);
    end
    tick();
    tests++;
    if (train_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got %b want 0", train_valid);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    push_br(32'h600, 1'b1, 10'd100);
    do_cycle(1'b1, 32'h604, 1'b0, 10'd100, 1'b1, 1'b1, 32'h0);
    do_cycle(1'b1, 32'h608, 1'b1, 10'd100, 1'b1, 1'b1, 32'h900);
    tests++;
    if ({flush_valid, flush_pc} !== {1'b1, 32'h900}) begin
      fails++;
      $display("FAIL sim_mis_flush: got %b/%h want 1/00000900",
               flush_valid, flush_pc);
    end
    resolve_br(1'b1, 32'h0);
    tests++;
    if (err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_set: got %b want 1", err_underflow);
    end
    for (int i = 0; i < 3; i++) tick();
    push_br(32'h700, 1'b0, 10'd100);
    tests++;
    if (err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky: got %b want 1", err_underflow);
    end
    do_reset();
    tests++;
    if (err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL underflow_clear: got %b want 0", err_underflow);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RES = 1'b0;
    pred_valid = 1'b0;
    pred_pc    = '0;
    pred_taken = 1'b0;
    pred_sum   = '0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    res_target = '0;
    train_ready = 1'b1;
    mghr  = '0;
    m_err = 1'b0;
    test_reset();
    test_fill();
    test_mispredict();
    test_low_conf();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
